decode_stage: RTL and testbench

- ID stage of the RV32I pipeline.
- Accepts fetched instructions over valid/ready and drives the read addresses of register_file.
- Captures the register_file read data, with writeback bypass, and decodes the immediate.
- Presents a registered ID/EX bundle to the execute stage.
- Also detects load-use hazards and inserts bubbles.

---
 rtl/rv32_pkg.sv | 27 ++
 rtl/imm_gen.sv | 49 ++++
 rtl/decode_stage.sv | 110 +++++++++++
 tb/tb_decode_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: base opcodes, immediate formats, default data width.
package rv32_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational instruction classifier: immediate, register usage, legality.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output logic        rs1_used,
  output logic        rs2_used,
  output logic        illegal
);

  imm_fmt_e fmt;

  // Opcode classification; the full 7-bit match also enforces instr[1:0]==2'b11
  always_comb begin
    fmt      = FMT_NONE;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    illegal  = 1'b0;
    case (instr[6:0])
      OPC_LUI:      begin fmt = FMT_U; rs1_used = 1'b0; end
      OPC_AUIPC:    begin fmt = FMT_U; rs1_used = 1'b0; end
      OPC_JAL:      begin fmt = FMT_J; rs1_used = 1'b0; end
      OPC_JALR:     fmt = FMT_I;
      OPC_BRANCH:   begin fmt = FMT_B; rs2_used = 1'b1; end
      OPC_LOAD:     fmt = FMT_I;
      OPC_STORE:    begin fmt = FMT_S; rs2_used = 1'b1; end
      OPC_OP_IMM:   fmt = FMT_I;
      OPC_OP:       rs2_used = 1'b1;
      OPC_MISC_MEM: fmt = FMT_NONE;
      OPC_SYSTEM:   fmt = FMT_NONE;
      default:      illegal = 1'b1;
    endcase
  end

  // Immediate assembly, sign bit is always instr[31]
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: handshake, operand capture with writeback bypass,
// load-use hazard bubbles and the ID/EX pipeline register.
module decode_stage
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      raddr_rs1,
  output logic [4:0]      raddr_rs2,
  input  logic [XLEN-1:0] rdata_rs1,
  input  logic [XLEN-1:0] rdata_rs2,
  input  logic            wb_we,
  input  logic [4:0]      wb_waddr,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  logic [31:0]     imm;
  logic            rs1_used;
  logic            rs2_used;
  logic            illegal;
  logic            hazard;
  logic            slot_free;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      held_rs1;
  logic [4:0]      held_rs2;

  imm_gen u_imm_gen (
    .instr    (in_instr),
    .imm      (imm),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .illegal  (illegal)
  );

  assign raddr_rs1 = in_instr[19:15];
  assign raddr_rs2 = in_instr[24:20];
  assign held_rs1  = out_instr[19:15];
  assign held_rs2  = out_instr[24:20];

  // Load-use hazard and handshake
  always_comb begin
    hazard = in_valid && ex_is_load && (ex_rd != 5'd0) &&
             (((ex_rd == raddr_rs1) && rs1_used) || ((ex_rd == raddr_rs2) && rs2_used));
    slot_free = !out_valid || out_ready;
    in_ready  = slot_free && !hazard && !flush;
  end

  // Operand selection: x0 reads zero, a same-cycle writeback wins over the regfile
  always_comb begin
    rs1_val = rdata_rs1;
    rs2_val = rdata_rs2;
    if (raddr_rs1 == 5'd0) rs1_val = '0;
    else if (wb_we && (wb_waddr == raddr_rs1)) rs1_val = wb_wdata;
    if (raddr_rs2 == 5'd0) rs2_val = '0;
    else if (wb_we && (wb_waddr == raddr_rs2)) rs2_val = wb_wdata;
  end

  // ID/EX pipeline register: flush > accept/bubble > hold with writeback refresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= RESET_PC;
      out_instr   <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (slot_free) begin
      if (in_valid && !hazard) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_instr   <= in_instr;
        out_rs1_val <= rs1_val;
        out_rs2_val <= rs2_val;
        out_imm     <= XLEN'($signed(imm));
        out_rd      <= in_instr[11:7];
        out_illegal <= illegal;
      end else begin
        out_valid <= 1'b0;
      end
    end else begin
      if (wb_we && (wb_waddr != 5'd0) && (wb_waddr == held_rs1)) out_rs1_val <= wb_wdata;
      if (wb_we && (wb_waddr != 5'd0) && (wb_waddr == held_rs2)) out_rs2_val <= wb_wdata;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RPC = 32'h0000_1000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      raddr_rs1;
  logic [4:0]      raddr_rs2;
  logic [XLEN-1:0] rdata_rs1;
  logic [XLEN-1:0] rdata_rs2;
  logic            wb_we;
  logic [4:0]      wb_waddr;
  logic [XLEN-1:0] wb_wdata;
  logic            ex_is_load;
  logic [4:0]      ex_rd;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rd;
  logic            out_illegal;

  logic [31:0] rf [32];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Register file model; x0 holds garbage so the stage must zero it itself
  always_comb begin
    rdata_rs1 = rf[raddr_rs1];
    rdata_rs2 = rf[raddr_rs2];
  end

  decode_stage #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .raddr_rs1   (raddr_rs1),
    .raddr_rs2   (raddr_rs2),
    .rdata_rs1   (rdata_rs1),
    .rdata_rs2   (rdata_rs2),
    .wb_we       (wb_we),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_rs1_val (out_rs1_val),
    .out_rs2_val (out_rs2_val),
    .out_imm     (out_imm),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    ex_is_load = 1'b0; ex_rd = '0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[0] = 32'h0000_1234; rf[1] = 32'd100; rf[2] = 32'd7; rf[4] = 32'd10;

    // Reset state
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, RPC);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("idle_bubble", 32'(out_valid), 32'd0);

    // ADDI x5,x1,-3
    in_valid = 1'b1; in_instr = 32'hFFD0_8293; in_pc = 32'h100;
    #1;
    chk("addi_in_ready", 32'(in_ready), 32'd1);
    chk("addi_raddr1", 32'(raddr_rs1), 32'd1);
    tick();
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_rs1", out_rs1_val, 32'd100);
    chk("addi_imm", out_imm, 32'hFFFF_FFFD);
    chk("addi_rd", 32'(out_rd), 32'd5);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_illegal", 32'(out_illegal), 32'd0);

    // ADD x3,x1,x2 with writeback bypass on x2
    in_instr = 32'h0020_81B3; in_pc = 32'h104;
    wb_we = 1'b1; wb_waddr = 5'd2; wb_wdata = 32'hDEAD_BEEF;
    #1;
    chk("add_raddr2", 32'(raddr_rs2), 32'd2);
    tick();
    chk("byp_rs2", out_rs2_val, 32'hDEAD_BEEF);
    chk("byp_rs1", out_rs1_val, 32'd100);
    chk("byp_rd", 32'(out_rd), 32'd3);
    chk("byp_imm", out_imm, 32'd0);
    chk("byp_pc", out_pc, 32'h104);

    // ADD x3,x0,x0 with writeback to x0: operands must be zero
    in_instr = 32'h0000_01B3; in_pc = 32'h108; wb_waddr = 5'd0;
    tick();
    chk("x0_rs1", out_rs1_val, 32'd0);
    chk("x0_rs2", out_rs2_val, 32'd0);

    // No writeback: regfile value used
    wb_we = 1'b0; wb_waddr = 5'd2; in_instr = 32'h0020_81B3; in_pc = 32'h10C;
    tick();
    chk("nobyp_rs2", out_rs2_val, 32'd7);

    // Load-use hazard on x1
    ex_is_load = 1'b1; ex_rd = 5'd1; in_pc = 32'h110;
    #1;
    chk("lu_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("lu_bubble", 32'(out_valid), 32'd0);
    ex_is_load = 1'b0;
    #1;
    chk("lu_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("lu_accept_valid", 32'(out_valid), 32'd1);
    chk("lu_accept_pc", out_pc, 32'h110);
    chk("lu_accept_rs1", out_rs1_val, 32'd100);

    // Load writes the rs2 field of an ADDI: rs2 unused, no hazard
    ex_is_load = 1'b1; ex_rd = 5'd29; in_instr = 32'hFFD0_8293; in_pc = 32'h114;
    #1;
    chk("unused_rs2_ready", 32'(in_ready), 32'd1);
    tick();
    chk("unused_rs2_pc", out_pc, 32'h114);
    ex_is_load = 1'b0;

    // ADDI x6,x4,1 then stall three cycles
    in_instr = 32'h0012_0313; in_pc = 32'h118;
    tick();
    chk("st_rs1", out_rs1_val, 32'd10);
    chk("st_rd", 32'(out_rd), 32'd6);
    out_ready = 1'b0; in_instr = 32'h0020_81B3; in_pc = 32'h11C;
    #1;
    chk("st_in_ready0", 32'(in_ready), 32'd0);
    tick();
    chk("st1_valid", 32'(out_valid), 32'd1);
    chk("st1_pc", out_pc, 32'h118);
    chk("st1_rs1", out_rs1_val, 32'd10);
    wb_we = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'd55;
    tick();
    rf[4] = 32'd55; wb_we = 1'b0;
    chk("st2_rs1_upd", out_rs1_val, 32'd55);
    chk("st2_pc", out_pc, 32'h118);
    chk("st2_imm", out_imm, 32'd1);
    chk("st2_rd", 32'(out_rd), 32'd6);
    chk("st2_instr", out_instr, 32'h0012_0313);
    chk("st2_in_ready", 32'(in_ready), 32'd0);
    ex_is_load = 1'b1; ex_rd = 5'd1;
    tick();
    chk("st3_valid", 32'(out_valid), 32'd1);
    chk("st3_pc", out_pc, 32'h118);
    chk("st3_rs1", out_rs1_val, 32'd55);
    ex_is_load = 1'b0;

    // Flush with a held bundle and a pending BEQ x1,x2,-8
    flush = 1'b1; in_instr = 32'hFE20_8CE3; in_pc = 32'h120;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("fl_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; out_ready = 1'b1;
    tick();
    chk("beq_valid", 32'(out_valid), 32'd1);
    chk("beq_pc", out_pc, 32'h120);
    chk("beq_imm", out_imm, 32'hFFFF_FFF8);
    chk("beq_rs2", out_rs2_val, 32'd7);

    // JAL x1,-4
    in_instr = 32'hFFDF_F0EF; in_pc = 32'h124;
    tick();
    chk("jal_imm", out_imm, 32'hFFFF_FFFC);
    chk("jal_rd", 32'(out_rd), 32'd1);

    // LUI x7,0x12345
    in_instr = 32'h1234_53B7; in_pc = 32'h128;
    tick();
    chk("lui_imm", out_imm, 32'h1234_5000);
    chk("lui_rd", 32'(out_rd), 32'd7);

    // SW x2,12(x1)
    in_instr = 32'h0020_A623; in_pc = 32'h12C;
    tick();
    chk("sw_imm", out_imm, 32'd12);

    // Unknown opcode and non-32-bit encoding
    in_instr = 32'h0000_007B; in_pc = 32'h130;
    tick();
    chk("ill_opc", 32'(out_illegal), 32'd1);
    chk("ill_opc_valid", 32'(out_valid), 32'd1);
    in_instr = 32'h0000_0002; in_pc = 32'h134;
    tick();
    chk("ill_len", 32'(out_illegal), 32'd1);
    chk("ill_len_imm", out_imm, 32'd0);

    // Reset asserted while holding
    in_instr = 32'h0012_0313; in_pc = 32'h138;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    chk("rh_hold_valid", 32'(out_valid), 32'd1);
    chk("rh_hold_pc", out_pc, 32'h138);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rh_valid", 32'(out_valid), 32'd0);
    chk("rh_pc", out_pc, RPC);
    chk("rh_rs1", out_rs1_val, 32'd0);
    #5;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
